// File: rtl/asrm_int_ctrl_pkg.sv
// Shared register offsets, FSM codes and bit helpers for the interrupt request controller.
// The optional edge-trigger feature is selected with `ASRM_INT_EDGE_EN.
package asrm_int_ctrl_pkg;

    localparam int unsigned NumSrc = 4;

    localparam logic [1:0] intctrl_enable  = 2'd0;
    localparam logic [1:0] intctrl_pending = 2'd1;
    localparam logic [1:0] intctrl_status  = 2'd2;
    localparam logic [1:0] intctrl_trigger = 2'd3;

    localparam logic [2:0] intc_idle = 3'd0;
    localparam logic [2:0] intc_req  = 3'd1;
    localparam logic [2:0] intc_ackd = 3'd2;

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic logic [1:0] prio_enc(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = NumSrc - 1; i >= 0; i--) begin
            if (v[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    function automatic logic [3:0] lowest_bit(input logic [3:0] v);
        return v & (~v + 4'd1);
    endfunction

endpackage

// File: rtl/asrm_int_ctrl_if.sv
// Request/acknowledge and configuration signals between the CPU side and the interrupt
// controller.
interface asrm_int_ctrl_if #(
    parameter int unsigned wordsize = 16
) ();
    logic [3:0]          irq_in;
    logic [3:0]          int_req;
    logic                int_ack;
    logic                int_done;
    logic                cfg_we;
    logic [1:0]          cfg_addr;
    logic [wordsize-1:0] cfg_wdata;
    logic [wordsize-1:0] cfg_rdata;

    modport master (
        output irq_in, int_ack, int_done, cfg_we, cfg_addr, cfg_wdata,
        input  int_req, cfg_rdata
    );

    modport slave (
        input  irq_in, int_ack, int_done, cfg_we, cfg_addr, cfg_wdata,
        output int_req, cfg_rdata
    );
endinterface

// File: rtl/asrm_int_sync.sv
// Two-flop synchroniser for one raw interrupt line; with `ASRM_INT_EDGE_EN it also
// flags the synchronised 0->1 transition.
module asrm_int_sync (
    input  logic clk,
    input  logic reset,
    input  logic irq_i,
    output logic sync_o,
    output logic rise_o
);
    logic meta_q, sync_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= irq_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

`ifdef ASRM_INT_EDGE_EN
    logic prev_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) prev_q <= 1'b0;
        else        prev_q <= sync_q;
    end

    assign rise_o = sync_q & ~prev_q;
`else
    assign rise_o = 1'b0;
`endif

endmodule

// File: rtl/asrm_int_ctrl.sv
// Four-source fixed-priority interrupt request controller with nesting and a register port.
// Defining `ASRM_INT_EDGE_EN adds the TRIGGER register for per-source edge mode.
module asrm_int_ctrl
    import asrm_int_ctrl_pkg::*;
#(
    parameter int unsigned wordsize = 16
) (
    input  logic             clk,
    input  logic             reset,
    asrm_int_ctrl_if.slave   bus
);
    logic [3:0] irq_s, rise;
    logic [3:0] enable_q, enable_d;
    logic [3:0] inserv_q, inserv_d;
    logic [3:0] pend_q, pend_d;
    logic [3:0] req_q, req_d;
    logic [2:0] state_q, state_d;
    logic [1:0] sel_q, sel_d;
    logic [3:0] trig;

    for (genvar g = 0; g < NumSrc; g++) begin : g_sync
        asrm_int_sync u_sync (
            .clk    (clk),
            .reset  (reset),
            .irq_i  (bus.irq_in[g]),
            .sync_o (irq_s[g]),
            .rise_o (rise[g])
        );
    end

    logic       wr_enable, wr_pending;
    logic [3:0] w1c;
    assign wr_enable  = bus.cfg_we && (bus.cfg_addr == intctrl_enable);
    assign wr_pending = bus.cfg_we && (bus.cfg_addr == intctrl_pending);
    assign w1c        = wr_pending ? bus.cfg_wdata[3:0] : 4'b0000;

`ifdef ASRM_INT_EDGE_EN
    logic [3:0] trig_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            trig_q <= 4'b0000;
        end else if (bus.cfg_we && (bus.cfg_addr == intctrl_trigger)) begin
            trig_q <= bus.cfg_wdata[3:0];
        end
    end
    assign trig = trig_q;
`else
    assign trig = 4'b0000;
`endif

    // Level sources follow the synchronised line directly; edge sources use the latch.
    logic [3:0] pending, active, cand_oh, le_mask;
    logic [1:0] cand;
    logic       eligible, sel_valid;

    assign pending   = (trig & pend_q) | (~trig & irq_s);
    assign active    = pending & enable_q;
    assign cand      = prio_enc(active);
    assign cand_oh   = lowest_bit(active);
    assign le_mask   = {cand_oh[2:0], 1'b0} - 4'd1;
    assign eligible  = (|active) && ((inserv_q & le_mask) == 4'b0000);
    assign sel_valid = pending[sel_q] & enable_q[sel_q];

    logic [3:0] set_is, ack_clr, done_clr;
    logic       ack_take;

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        req_d    = req_q;
        set_is   = 4'b0000;
        ack_clr  = 4'b0000;
        ack_take = 1'b0;
        case (state_q)
            intc_idle: begin
                if (eligible) begin
                    state_d = intc_req;
                    sel_d   = cand;
                    req_d   = cand_oh;
                end
            end
            intc_req: begin
                // An ack in the same cycle the source drops still counts as taken.
                if (bus.int_ack) begin
                    state_d  = intc_ackd;
                    req_d    = 4'b0000;
                    set_is   = req_q;
                    ack_clr  = req_q;
                    ack_take = 1'b1;
                end else if (!sel_valid) begin
                    state_d = intc_idle;
                    req_d   = 4'b0000;
                end
            end
            intc_ackd: state_d = intc_idle;
            default: begin
                state_d = intc_idle;
                req_d   = 4'b0000;
            end
        endcase
    end

    // A retint coinciding with a taken interrupt is dropped.
    assign done_clr = (bus.int_done && !ack_take) ? lowest_bit(inserv_q) : 4'b0000;
    assign inserv_d = (inserv_q & ~done_clr) | set_is;
    assign pend_d   = trig & (rise | (pend_q & ~w1c & ~ack_clr));
    assign enable_d = wr_enable ? bus.cfg_wdata[3:0] : enable_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= intc_idle;
            sel_q    <= 2'd0;
            req_q    <= 4'b0000;
            enable_q <= 4'b0000;
            inserv_q <= 4'b0000;
            pend_q   <= 4'b0000;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            req_q    <= req_d;
            enable_q <= enable_d;
            inserv_q <= inserv_d;
            pend_q   <= pend_d;
        end
    end

    assign bus.int_req = req_q;

    logic [7:0] rdata8;
    always_comb begin
        rdata8 = 8'h00;
        case (bus.cfg_addr)
            intctrl_enable:  rdata8 = {4'b0000, enable_q};
            intctrl_pending: rdata8 = {4'b0000, pending};
            intctrl_status:  rdata8 = {|req_q, state_q, inserv_q};
            intctrl_trigger: rdata8 = {4'b0000, trig};
            default:         rdata8 = 8'h00;
        endcase
    end

    assign bus.cfg_rdata = {{(wordsize - 8){1'b0}}, rdata8};

    logic unused_wdata;
    assign unused_wdata = ^bus.cfg_wdata[wordsize-1:4];

endmodule
